// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/write-back.
// Optional feature: define MCTRL_ILLEGAL_TRAP_EN to trap illegal opcodes (otherwise they are NOPs).
module multicycle_ctrl #(
    parameter logic [1:0] RESET_PC_SEL = 2'b00,
    parameter logic [1:0] TRAP_VEC_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic [1:0] pcSource,
    output logic [2:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_BNE  = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    // Next-state selection; opcode is held stable by the datapath after DECODE.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                             w_next_state = S_R_EXEC;
                    OP_LW, OP_SW:                         w_next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                       w_next_state = S_BRANCH;
                    OP_J:                                 w_next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:    w_next_state = S_I_EXEC;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:                              w_next_state = S_TRAP;
`else
                    default:                              w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_SW) begin
                    w_next_state = S_MEM_WR;
                end else begin
                    w_next_state = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_next_state = S_MEM_WB;
                end else begin
                    w_next_state = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEM_WR;
                end
            end
            S_R_EXEC: w_next_state = S_R_WB;
            S_I_EXEC: w_next_state = S_I_WB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State register; reset has priority even over a pending memory stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic r_illegal_op;

    // Sticky flag, raised together with the entry into TRAP so it is visible there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_op <= 1'b0;
        end else if (w_next_state == S_TRAP) begin
            r_illegal_op <= 1'b1;
        end else begin
            r_illegal_op <= r_illegal_op;
        end
    end

    assign illegal_op = r_illegal_op;
`else
    assign illegal_op = 1'b0;
`endif

    assign state = r_state;

    // Moore decode of datapath controls; only irWrite/pcWrite in FETCH follow mem_ready.
    always_comb begin
        mem_req     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSource    = RESET_PC_SEL;
        aluOp       = ALU_ADD;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    memRead  = 1'b1;
                    iorD     = 1'b0;
                    aluSrcA  = 1'b0;
                    aluSrcB  = 2'b01;
                    aluOp    = ALU_ADD;
                    pcSource = RESET_PC_SEL;
                    irWrite  = mem_ready;
                    pcWrite  = mem_ready;
                end
                S_DECODE: begin
                    aluSrcA = 1'b0;
                    aluSrcB = 2'b11;
                    aluOp   = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                    aluOp   = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                S_MEM_WB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b0;
                    memToReg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                S_R_EXEC: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b00;
                    aluOp   = ALU_FUNC;
                end
                S_R_WB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                    memToReg = 1'b0;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluSrcB     = 2'b00;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'b01;
                    // For bne the ALU reports zero when the operands differ.
                    if (opcode == OP_BNE) begin
                        aluOp = ALU_BNE;
                    end else begin
                        aluOp = ALU_SUB;
                    end
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = 2'b10;
                end
                S_I_EXEC: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                    case (opcode)
                        OP_ANDI: aluOp = ALU_AND;
                        OP_ORI:  aluOp = ALU_OR;
                        OP_SLTI: aluOp = ALU_SLT;
                        default: aluOp = ALU_ADD;
                    endcase
                end
                S_I_WB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b0;
                    memToReg = 1'b0;
                end
                S_TRAP: begin
                    pcSource = TRAP_VEC_SEL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    pcWrite  = 1'b1;
`else
                    pcWrite  = 1'b0;
`endif
                end
                default: begin
                    pcSource = RESET_PC_SEL;
                end
            endcase
        end else begin
            pcSource = RESET_PC_SEL;
            aluOp    = ALU_ADD;
        end
    end

endmodule
